// File: rtl/range_sweep_gen.sv
// Range sweep generator: emits a FULL/RANGE/WRAP/PINGPONG value sequence over valid/ready.
// Optional beat counter output enabled by RANGE_SWEEP_GEN_BEAT_CNT_EN.
module range_sweep_gen #(
  parameter int WIDTH  = 8,
  parameter int HOLD_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  cfg_start,
  input  logic [WIDTH-1:0]  cfg_stop,
  input  logic [WIDTH-1:0]  cfg_step,
  input  logic [HOLD_W-1:0] cfg_hold,
  input  logic [1:0]        cfg_mode,
  input  logic              go,
  input  logic              abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef RANGE_SWEEP_GEN_BEAT_CNT_EN
  ,
  output logic [31:0]       beat_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EMIT,
    S_HOLD
  } state_e;

  localparam logic [1:0] M_FULL  = 2'd0;
  localparam logic [1:0] M_RANGE = 2'd1;
  localparam logic [1:0] M_WRAP  = 2'd2;
  localparam logic [1:0] M_PP    = 2'd3;
  localparam int         W1      = WIDTH + 1;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    cur_q, cur_d;
  logic [WIDTH-1:0]    start_q, start_d;
  logic [WIDTH-1:0]    stop_q, stop_d;
  logic [WIDTH-1:0]    step_q, step_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [HOLD_W-1:0]   hcnt_q, hcnt_d;
  logic [1:0]          mode_q, mode_d;
  logic                dir_q, dir_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [WIDTH-1:0]    eff_start, eff_stop, eff_step;
  logic                bad_cfg, go_ok, fire;
  logic [W1-1:0]       cur_x, stop_x, up_sum, lo_sum;
  logic                is_last;
  logic [WIDTH-1:0]    cur_nx;
  logic                dir_nx;

  assign out_valid = (state_q == S_EMIT);
  assign out_data  = cur_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign fire      = out_valid && out_ready;

  always_comb begin
    eff_start = cfg_start;
    eff_stop  = cfg_stop;
    eff_step  = cfg_step;
    if (cfg_mode == M_FULL) begin
      eff_start = '0;
      eff_stop  = '1;
      eff_step  = WIDTH'(1);
    end
  end

  assign bad_cfg = (cfg_mode != M_FULL) &&
                   ((cfg_step == '0) || (cfg_start > cfg_stop));
  assign go_ok   = (state_q == S_IDLE) && go && !abort && !bad_cfg;

  // Bounds are compared one bit wider so cur+step can never wrap.
  assign cur_x   = {1'b0, cur_q};
  assign stop_x  = {1'b0, stop_q};
  assign up_sum  = cur_x + {1'b0, step_q};
  assign lo_sum  = {1'b0, start_q} + {1'b0, step_q};
  assign is_last = dir_q ? (cur_x < lo_sum) : (up_sum > stop_x);
  assign out_last = out_valid && is_last;

  always_comb begin
    cur_nx = dir_q ? (cur_q - step_q) : (cur_q + step_q);
    dir_nx = dir_q;
    if (is_last) begin
      unique case (mode_q)
        M_WRAP: cur_nx = start_q;
        M_PP: begin
          dir_nx = !dir_q;
          // Turn around, but stay put if the reflected step leaves the range.
          if (!dir_q) begin
            cur_nx = (cur_x >= lo_sum) ? (cur_q - step_q) : cur_q;
          end else begin
            cur_nx = (up_sum <= stop_x) ? (cur_q + step_q) : cur_q;
          end
        end
        default: cur_nx = cur_q;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    start_d = start_q;
    stop_d  = stop_q;
    step_d  = step_q;
    hold_d  = hold_q;
    hcnt_d  = hcnt_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (go && !abort) begin
          if (bad_cfg) begin
            err_d = 1'b1;
          end else begin
            start_d = eff_start;
            stop_d  = eff_stop;
            step_d  = eff_step;
            hold_d  = cfg_hold;
            mode_d  = cfg_mode;
            cur_d   = eff_start;
            dir_d   = 1'b0;
            state_d = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (fire) begin
          cur_d = cur_nx;
          dir_d = dir_nx;
          if (is_last && (mode_q == M_FULL || mode_q == M_RANGE)) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else if (hold_q != '0) begin
            hcnt_d  = hold_q;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (hcnt_q == HOLD_W'(1)) begin
          hcnt_d  = '0;
          state_d = S_EMIT;
        end else begin
          hcnt_d = hcnt_q - HOLD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      start_q <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      hold_q  <= '0;
      hcnt_q  <= '0;
      mode_q  <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      step_q  <= step_d;
      hold_q  <= hold_d;
      hcnt_q  <= hcnt_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

`ifdef RANGE_SWEEP_GEN_BEAT_CNT_EN
  logic [31:0] bcnt_q, bcnt_d;

  always_comb begin
    bcnt_d = bcnt_q;
    if (go_ok) begin
      bcnt_d = '0;
    end else if (fire && bcnt_q != '1) begin
      bcnt_d = bcnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_q <= '0;
    end else begin
      bcnt_q <= bcnt_d;
    end
  end

  assign beat_cnt = bcnt_q;
`else
  logic unused_go_ok;
  assign unused_go_ok = go_ok;
`endif

endmodule

// File: tb/tb_range_sweep_gen.sv
// Scoreboard bench for range_sweep_gen: a WIDTH=4 instance for the full sweep,
// a WIDTH=8 instance for range/wrap/pingpong/hold/abort/error cases.
module tb_range_sweep_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  s8 = '0, p8 = '0, t8 = '0;
  logic [15:0] h8 = '0;
  logic [1:0]  m8 = '0;
  logic        go8 = 1'b0, ab8 = 1'b0, rdy8 = 1'b1;
  logic        v8, l8, bz8, dn8, er8;
  logic [7:0]  d8;

  logic [3:0]  s4 = '0, p4 = '0, t4 = '0;
  logic [15:0] h4 = '0;
  logic [1:0]  m4 = '0;
  logic        go4 = 1'b0, ab4 = 1'b0, rdy4 = 1'b1;
  logic        v4, l4, bz4, dn4, er4;
  logic [3:0]  d4;

`ifdef RANGE_SWEEP_GEN_BEAT_CNT_EN
  logic [31:0] bc8, bc4;
`endif

  range_sweep_gen #(.WIDTH(8), .HOLD_W(16)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .cfg_start(s8), .cfg_stop(p8), .cfg_step(t8),
    .cfg_hold(h8), .cfg_mode(m8),
    .go(go8), .abort(ab8),
    .out_valid(v8), .out_ready(rdy8), .out_data(d8),
    .out_last(l8), .busy(bz8), .done(dn8), .err(er8)
`ifdef RANGE_SWEEP_GEN_BEAT_CNT_EN
    , .beat_cnt(bc8)
`endif
  );

  range_sweep_gen #(.WIDTH(4), .HOLD_W(16)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .cfg_start(s4), .cfg_stop(p4), .cfg_step(t4),
    .cfg_hold(h4), .cfg_mode(m4),
    .go(go4), .abort(ab4),
    .out_valid(v4), .out_ready(rdy4), .out_data(d4),
    .out_last(l4), .busy(bz4), .done(dn4), .err(er4)
`ifdef RANGE_SWEEP_GEN_BEAT_CNT_EN
    , .beat_cnt(bc4)
`endif
  );

  int n_run = 0;
  int n_fail = 0;
  logic [8:0] q8[$];
  logic [4:0] q4[$];
  int ndone8 = 0, nerr8 = 0, nval8 = 0, nerr4 = 0;
  logic stall8 = 1'b0;
  logic [8:0] held8 = '0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [8:0] e;
    if (stall8) chk("stall_hold", {23'b0, l8, d8}, {23'b0, held8});
    stall8 = v8 && !rdy8;
    held8  = {l8, d8};
    if (v8) nval8++;
    if (dn8) ndone8++;
    if (er8) nerr8++;
    if (v8 && rdy8) begin
      if (q8.size() == 0) begin
        chk("extra_beat8", {23'b0, l8, d8}, 32'hFFFF_FFFF);
      end else begin
        e = q8.pop_front();
        chk("beat8", {23'b0, l8, d8}, {23'b0, e});
      end
    end
  end

  always @(negedge clk) begin
    logic [4:0] e;
    if (er4) nerr4++;
    if (v4 && rdy4) begin
      if (q4.size() == 0) begin
        chk("extra_beat4", {27'b0, l4, d4}, 32'hFFFF_FFFF);
      end else begin
        e = q4.pop_front();
        chk("beat4", {27'b0, l4, d4}, {27'b0, e});
      end
    end
  end

  task automatic push_range8(input int s, input int p, input int t);
    logic [8:0] e;
    for (int v = s; v <= p; v += t) begin
      e = {(v + t > p), v[7:0]};
      q8.push_back(e);
    end
  endtask

  task automatic pulse_go8();
    @(posedge clk);
    #1 go8 = 1'b1;
    @(posedge clk);
    #1 go8 = 1'b0;
  endtask

  task automatic wait_ev(input bit w4, input int budget, output int cyc,
                         output bit dn, output bit er);
    cyc = 0;
    dn = 1'b0;
    er = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      cyc++;
      if (w4 ? dn4 : dn8) begin
        dn = 1'b1;
        break;
      end
      if (!w4 && er8) begin
        er = 1'b1;
        break;
      end
    end
  endtask

  task automatic set8(input int s, input int p, input int t,
                      input int h, input int m);
    s8 = 8'(s);
    p8 = 8'(p);
    t8 = 8'(t);
    h8 = 16'(h);
    m8 = 2'(m);
  endtask

  task automatic run8(input string tag, input int s, input int p,
                      input int t, input int h, input int exp_cyc,
                      input int exp_val);
    int cyc, d0, v0;
    bit dn, er;
    set8(s, p, t, h, 1);
    push_range8(s, p, t);
    d0 = ndone8;
    v0 = nval8;
    pulse_go8();
    wait_ev(1'b0, 2000, cyc, dn, er);
    chk({tag, "_done"}, {31'b0, dn}, 32'd1);
    chk({tag, "_cyc"}, cyc, exp_cyc);
    chk({tag, "_busy"}, {31'b0, bz8}, 32'd0);
    repeat (3) @(negedge clk);
    chk({tag, "_ndone"}, ndone8 - d0, 32'd1);
    chk({tag, "_nvalid"}, nval8 - v0, exp_val);
    chk({tag, "_qempty"}, q8.size(), 32'd0);
  endtask

  task automatic err8(input string tag, input int s, input int p,
                      input int t, input int m);
    int cyc, d0, v0;
    bit dn, er;
    set8(s, p, t, 0, m);
    d0 = ndone8;
    v0 = nval8;
    pulse_go8();
    wait_ev(1'b0, 10, cyc, dn, er);
    chk({tag, "_err"}, {31'b0, er}, 32'd1);
    chk({tag, "_cyc"}, cyc, 32'd1);
    chk({tag, "_busy"}, {31'b0, bz8}, 32'd0);
    repeat (3) @(negedge clk);
    chk({tag, "_nvalid"}, nval8 - v0, 32'd0);
    chk({tag, "_ndone"}, ndone8 - d0, 32'd0);
  endtask

  initial begin
    int cyc, d0, e0;
    bit dn, er;
    int pp_v[10] = '{2, 4, 6, 4, 2, 4, 6, 4, 2, 4};
    int pp_l[10] = '{0, 0, 1, 0, 1, 0, 1, 0, 1, 0};
    int wr_v[8]  = '{1, 4, 7, 1, 4, 7, 1, 4};
    int wr_l[8]  = '{0, 0, 1, 0, 0, 1, 0, 0};
    logic [8:0] e;

    #12;
    chk("rst_valid", {31'b0, v8}, 32'd0);
    chk("rst_busy", {31'b0, bz8}, 32'd0);
    chk("rst_done", {31'b0, dn8}, 32'd0);
    chk("rst_err", {31'b0, er8}, 32'd0);
    chk("rst_data", {24'b0, d8}, 32'd0);
`ifdef RANGE_SWEEP_GEN_BEAT_CNT_EN
    chk("rst_bcnt", bc8, 32'd0);
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Full sweep on the 4-bit instance; junk cfg must be overridden.
    for (int v = 0; v < 16; v++) begin
      logic [4:0] e4;
      e4 = {(v == 15), v[3:0]};
      q4.push_back(e4);
    end
    s4 = 4'd5;
    p4 = 4'd2;
    t4 = 4'd0;
    m4 = 2'd0;
    @(posedge clk);
    #1 go4 = 1'b1;
    @(posedge clk);
    #1 go4 = 1'b0;
    wait_ev(1'b1, 100, cyc, dn, er);
    chk("full_done", {31'b0, dn}, 32'd1);
    chk("full_cyc", cyc, 32'd17);
    chk("full_busy", {31'b0, bz4}, 32'd0);
    chk("full_qempty", q4.size(), 32'd0);
    chk("full_noerr", nerr4, 32'd0);
`ifdef RANGE_SWEEP_GEN_BEAT_CNT_EN
    repeat (2) @(negedge clk);
    chk("full_bcnt", bc4, 32'd16);
`endif

    run8("rng3", 3, 10, 3, 0, 4, 3);
    run8("rng250", 250, 255, 4, 0, 3, 2);
    run8("hold2", 0, 3, 1, 2, 11, 4);
`ifdef RANGE_SWEEP_GEN_BEAT_CNT_EN
    chk("hold2_bcnt", bc8, 32'd4);
`endif

    // Backpressure while data=2.
    set8(0, 5, 1, 0, 1);
    push_range8(0, 5, 1);
    d0 = ndone8;
    pulse_go8();
    repeat (2) @(posedge clk);
    #1 rdy8 = 1'b0;
    chk("bp_data", {24'b0, d8}, 32'd2);
    chk("bp_valid", {31'b0, v8}, 32'd1);
    repeat (3) @(posedge clk);
    #1 rdy8 = 1'b1;
    wait_ev(1'b0, 100, cyc, dn, er);
    chk("bp_done", {31'b0, dn}, 32'd1);
    repeat (2) @(negedge clk);
    chk("bp_qempty", q8.size(), 32'd0);
    chk("bp_ndone", ndone8 - d0, 32'd1);

    // Ping-pong, abort coinciding with the 10th handshake.
    set8(2, 6, 2, 0, 3);
    for (int i = 0; i < 10; i++) begin
      e = {pp_l[i][0], pp_v[i][7:0]};
      q8.push_back(e);
    end
    d0 = ndone8;
    pulse_go8();
    repeat (9) @(posedge clk);
    #1 ab8 = 1'b1;
    @(posedge clk);
    #1 ab8 = 1'b0;
    @(negedge clk);
    chk("pp_valid", {31'b0, v8}, 32'd0);
    chk("pp_busy", {31'b0, bz8}, 32'd0);
    repeat (2) @(negedge clk);
    chk("pp_qempty", q8.size(), 32'd0);
    chk("pp_ndone", ndone8 - d0, 32'd0);
`ifdef RANGE_SWEEP_GEN_BEAT_CNT_EN
    chk("pp_bcnt", bc8, 32'd10);
`endif

    // Wrap, with a go and new cfg while busy that must be ignored.
    set8(1, 7, 3, 0, 2);
    for (int i = 0; i < 8; i++) begin
      e = {wr_l[i][0], wr_v[i][7:0]};
      q8.push_back(e);
    end
    d0 = ndone8;
    pulse_go8();
    @(posedge clk);
    #1 go8 = 1'b1;
    set8(0, 200, 1, 5, 0);
    @(posedge clk);
    #1 go8 = 1'b0;
    repeat (5) @(posedge clk);
    #1 ab8 = 1'b1;
    @(posedge clk);
    #1 ab8 = 1'b0;
    @(negedge clk);
    chk("wr_valid", {31'b0, v8}, 32'd0);
    repeat (2) @(negedge clk);
    chk("wr_qempty", q8.size(), 32'd0);
    chk("wr_ndone", ndone8 - d0, 32'd0);

    err8("err_step0", 1, 5, 0, 1);
    err8("err_order", 9, 4, 1, 1);
    err8("err_pp", 9, 4, 1, 3);

    // Asynchronous reset mid-sweep.
    set8(0, 200, 1, 0, 1);
    push_range8(0, 200, 1);
    d0 = ndone8;
    e0 = nerr8;
    pulse_go8();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, v8}, 32'd0);
    chk("arst_busy", {31'b0, bz8}, 32'd0);
    q8.delete();
    repeat (2) @(negedge clk);
    chk("arst_ndone", ndone8 - d0, 32'd0);
    chk("arst_nerr", nerr8 - e0, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/range_sweep_gen.md
Name: range_sweep_gen

Overview:
- Synthesizable, parametrised value-sweep generator for on-chip self-test and bench stimulus.
- Emits a configurable integer sequence over a valid/ready stream, with programmable inter-beat hold.
- Sequence types: full-range, bounded range, repeating wrap, or ping-pong.
- Sits between a config/control source and any DUT input port needing swept stimulus.

Parameters:
- WIDTH, 8, data width in bits; all sweep arithmetic uses WIDTH+1 bits internally.
- HOLD_W, 16, width of the inter-beat hold counter.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cfg_start  in  WIDTH  first value (unsigned)
- cfg_stop  in  WIDTH  last value, inclusive (unsigned)
- cfg_step  in  WIDTH  increment magnitude (unsigned)
- cfg_hold  in  HOLD_W  idle cycles inserted after each accepted beat
- cfg_mode  in  2  0=FULL, 1=RANGE, 2=WRAP, 3=PINGPONG
- go  in  1  start pulse; sampled only in IDLE
- abort  in  1  terminate sweep
- out_valid  out  1  beat valid
- out_ready  in  1  downstream accept
- out_data  out  WIDTH  current value
- out_last  out  1  final beat of a pass (qualified by out_valid)
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse on normal completion
- err  out  1  one-cycle pulse on rejected configuration

Behaviour:
- Reset: all outputs 0; FSM in IDLE; internal counters 0.
- FSM states: IDLE, EMIT, HOLD.
- IDLE, go=1:
  - Latch cfg_*.
  - FULL mode forces start=0, stop=2^WIDTH-1, step=1.
  - Reject if step==0 or start>stop (modes 1-3): err=1 next cycle, remain IDLE.
  - Otherwise cur=start, direction=up, go to EMIT. First out_valid one cycle after go.
- EMIT:
  - out_valid=1, out_data=cur.
  - out_data and out_last are held stable while out_valid && !out_ready.
  - Beat accepted when out_valid && out_ready.
- Last-beat detection:
  - Up direction: cur+step > stop, evaluated in WIDTH+1 bits; no wrap-around overflow permitted.
  - Down direction: cur < start+step, evaluated in WIDTH+1 bits.
- After an accepted beat:
  - FULL / RANGE, last beat: done=1 next cycle, go to IDLE.
  - WRAP, last beat: cur=start, continue.
  - PINGPONG, last beat: reverse direction; cur=cur-step (or cur+step). If start==stop, cur stays and every beat is last.
  - Not last: cur += step (up) or cur -= step (down).
  - If cfg_hold>0: go to HOLD (out_valid=0) for exactly cfg_hold cycles, then EMIT. Otherwise remain in EMIT; back-to-back beats every cycle.
- out_last:
  - FULL / RANGE: the final value.
  - WRAP: the value preceding the return to start.
  - PINGPONG: each turning-point value.
- WRAP and PINGPONG never self-terminate; only abort ends them.
- abort (any non-IDLE state): go to IDLE next cycle; out_valid=0 next cycle; no done.
  - If abort coincides with a handshake, that beat counts as transferred; no further beats.
  - abort in IDLE is ignored.
  - abort and go together in IDLE: go is ignored.
- go while busy: ignored; latched config is unaffected.
- cfg_* changes while busy have no effect.
- Reset mid-sweep: immediate return to reset values; no done, no err.

Optional Feature:
- Macro: RANGE_SWEEP_GEN_BEAT_CNT_EN.
- Defined:
  - Adds output port beat_cnt [31:0].
  - Cleared on accepted go; increments on each accepted beat; saturates at 2^32-1.
  - Holds its value after done or abort until the next accepted go; reset value 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
1. WIDTH=4, FULL, hold=0, ready=1, go -> out_data 0..15 on consecutive cycles, out_last only with 15, done pulse on the cycle after beat 15, busy falls with done.
2. RANGE, start=3 stop=10 step=3 -> beats 3,6,9; last on 9; done once. WIDTH=8 start=250 stop=255 step=4 -> beats 250,254; last on 254; no overflow.
3. RANGE 0..5 step 1; drop out_ready for 3 cycles while out_data=2 -> out_data holds 2 with valid high; sequence resumes 3,4,5 with no skipped or duplicated value.
4. PINGPONG, start=2 stop=6 step=2 -> 2,4,6,4,2,4,6...; last on each 6 and each 2 after the first; abort mid-stream -> valid low next cycle, no done, busy 0.
5. RANGE 0..3 step 1, hold=2, ready=1 -> valid pulses every 3 cycles; values 0,1,2,3; done after 3.
6. go with step=0 -> err pulse only, busy stays 0, no valid. go with start=9 stop=4 mode RANGE -> err. With macro defined: full WIDTH=4 sweep -> beat_cnt=16 after done.
